// File: rtl/bus_arb_nxm_if.sv
// -----------------------------------------------------------------------------
// bus_arb_nxm_if
//
// Purpose
//   Bundles the shared-bus signals of bus_arb_nxm: the request/address/data
//   lanes of every master, the broadcast read-data and grant returned to them,
//   and the forwarded address/data path plus per-slave read data on the slave
//   side. Master and slave lanes are flattened into packed vectors:
//   master i lives at [i*ADDR_W +: ADDR_W] / [i*DATA_W +: DATA_W], slave j at
//   [j*DATA_W +: DATA_W].
//
// Signals
//   m_req      N_MASTER         per-master bus request
//   m_wr       N_MASTER         per-master write strobe (1 = write)
//   m_address  N_MASTER*ADDR_W  flattened master addresses
//   m_dout     N_MASTER*DATA_W  flattened master write data
//   m_grant    N_MASTER         registered one-hot (or zero) grant
//   m_din      DATA_W           read data broadcast to all masters
//   s_sel      N_SLAVE          one-hot slave select
//   s_address  ADDR_W           address forwarded from the owner
//   s_wr       1                write strobe forwarded from the owner
//   s_din      DATA_W           write data forwarded from the owner
//   s_dout     N_SLAVE*DATA_W   flattened slave read data
//
// Modports
//   arb     the arbiter / interconnect itself
//   master  what a bus master drives and observes
//   slave   what a memory-mapped slave drives and observes
// -----------------------------------------------------------------------------
interface bus_arb_nxm_if #(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 4,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 64
);

    // Master side
    logic [N_MASTER-1:0]        m_req;
    logic [N_MASTER-1:0]        m_wr;
    logic [N_MASTER*ADDR_W-1:0] m_address;
    logic [N_MASTER*DATA_W-1:0] m_dout;
    logic [N_MASTER-1:0]        m_grant;
    logic [DATA_W-1:0]          m_din;

    // Slave side
    logic [N_SLAVE-1:0]         s_sel;
    logic [ADDR_W-1:0]          s_address;
    logic                       s_wr;
    logic [DATA_W-1:0]          s_din;
    logic [N_SLAVE*DATA_W-1:0]  s_dout;

    modport arb (
        input  m_req, m_wr, m_address, m_dout, s_dout,
        output m_grant, m_din, s_sel, s_address, s_wr, s_din
    );

    modport master (
        output m_req, m_wr, m_address, m_dout,
        input  m_grant, m_din
    );

    modport slave (
        input  s_sel, s_address, s_wr, s_din,
        output s_dout
    );

endinterface : bus_arb_nxm_if

// File: rtl/bus_arb_nxm.sv
// -----------------------------------------------------------------------------
// bus_arb_nxm
//
// Purpose
//   Shared-bus interconnect for N_MASTER masters and N_SLAVE memory-mapped
//   slaves. A round-robin arbiter hands out a registered one-hot grant; the
//   current owner's address, write strobe and write data are forwarded to the
//   slaves combinationally while it keeps requesting. The upper address bits
//   (m_address[ADDR_W-1:WIN_SHIFT]) pick the slave; each window is
//   2^WIN_SHIFT bytes and an index >= N_SLAVE selects nothing. Read data is
//   returned one cycle after the select cycle, matching slaves that register
//   their read port (RAM, factorial core).
//
// Ports
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   bus      arb modport of bus_arb_nxm_if (see that file for the signal list)
//
// Parameters
//   N_MASTER   number of masters (2..8)
//   N_SLAVE    number of slaves (1..16)
//   ADDR_W     address width
//   DATA_W     data width
//   WIN_SHIFT  log2 of the per-slave address window in bytes
//   HOLD_MAX   maximum consecutive owned cycles (hold-limit build only)
//
// Build option
//   BUS_HOLD_LIMIT_EN  when defined, an owner that has held the bus for
//                      HOLD_MAX consecutive cycles is pre-empted at the next
//                      edge if any other master is requesting. When not
//                      defined, an owner keeps the bus for as long as it
//                      requests and no counter exists.
// -----------------------------------------------------------------------------
module bus_arb_nxm #(
    parameter int N_MASTER  = 2,
    parameter int N_SLAVE   = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 64,
    parameter int WIN_SHIFT = 11,
    parameter int HOLD_MAX  = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    bus_arb_nxm_if.arb bus
);

    localparam int MIDX_W = $clog2(N_MASTER);
    localparam int SIDX_W = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
    localparam int WIN_W  = ADDR_W - WIN_SHIFT;

    // Elaboration-time guard on the supported configuration space.
    if (N_MASTER < 2 || N_MASTER > 8) begin : g_bad_n_master
        $error("bus_arb_nxm: N_MASTER must be in 2..8");
    end
    if (N_SLAVE < 1 || N_SLAVE > 16) begin : g_bad_n_slave
        $error("bus_arb_nxm: N_SLAVE must be in 1..16");
    end
    if (WIN_SHIFT < 3 || WIN_SHIFT >= ADDR_W) begin : g_bad_win_shift
        $error("bus_arb_nxm: WIN_SHIFT must lie inside the address");
    end
    if (HOLD_MAX < 1) begin : g_bad_hold_max
        $error("bus_arb_nxm: HOLD_MAX must be at least 1");
    end

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    state_t              state;
    logic [N_MASTER-1:0] grant;     // one-hot copy of owner while OWNED
    logic [MIDX_W-1:0]   owner;     // binary index of the current owner
    logic [MIDX_W-1:0]   rr_ptr;    // last winner; search starts just above it
    logic                rd_vld;    // a read hit a slave in the previous cycle
    logic [SIDX_W-1:0]   rd_idx;    // which slave that read went to

    // -------------------------------------------------------------------------
    // Owner view of the master lanes
    // -------------------------------------------------------------------------
    logic                own_req;
    logic                own_wr;
    logic [ADDR_W-1:0]   own_addr;
    logic [DATA_W-1:0]   own_dout;
    logic                active;
    logic [WIN_W-1:0]    win;
    logic                hit;

    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned and no latch is
    // inferred.
    always_comb begin
        own_req  = 1'b0;
        own_wr   = 1'b0;
        own_addr = '0;
        own_dout = '0;
        for (int i = 0; i < N_MASTER; i++) begin
            if (owner == MIDX_W'(i)) begin
                own_req  = bus.m_req[i];
                own_wr   = bus.m_wr[i];
                own_addr = bus.m_address[i*ADDR_W +: ADDR_W];
                own_dout = bus.m_dout[i*DATA_W +: DATA_W];
            end
        end
    end

    // A transfer needs both the grant and a still-asserted request: an owner
    // that has just dropped its request is not on the bus in that cycle.
    assign active = (state == OWNED) && own_req;
    assign win    = own_addr[ADDR_W-1:WIN_SHIFT];
    // Compare at 32 bits so narrow window fields never alias onto N_SLAVE.
    assign hit    = 32'(win) < N_SLAVE;

    // -------------------------------------------------------------------------
    // Slave-side forwarding
    // -------------------------------------------------------------------------
    logic [N_SLAVE-1:0] sel;

    always_comb begin
        sel = '0;
        for (int j = 0; j < N_SLAVE; j++) begin
            sel[j] = active && (32'(win) == 32'(j));
        end
    end

    // An out-of-range window leaves sel at zero, so writes there reach no
    // slave even though s_wr is still forwarded.
    assign bus.s_sel     = sel;
    assign bus.s_wr      = active & own_wr;
    assign bus.s_address = active ? own_addr : '0;
    assign bus.s_din     = active ? own_dout : '0;

    // -------------------------------------------------------------------------
    // Read return: the slave registered its data at the select edge, so pick
    // it up with the index captured at that same edge.
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < N_SLAVE; j++) begin
            if (rd_vld && (rd_idx == SIDX_W'(j))) begin
                rd_data = bus.s_dout[j*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.m_din   = rd_data;
    assign bus.m_grant = grant;

    // -------------------------------------------------------------------------
    // Hold limit
    // -------------------------------------------------------------------------
    logic hold_expire;

`ifdef BUS_HOLD_LIMIT_EN
    localparam int HCNT_W = $clog2(HOLD_MAX + 1);

    logic [HCNT_W-1:0] hold_cnt;    // owned cycles so far, 1 in the first

    // Pre-emption only makes sense when someone else is waiting; a lone
    // owner just has its count restarted.
    assign hold_expire = (state == OWNED)
                      && (hold_cnt == HCNT_W'(HOLD_MAX))
                      && |(bus.m_req & ~grant);
`else
    assign hold_expire = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Round-robin search: first eligible master above rr_ptr, with wrap. The
    // last candidate examined is rr_ptr itself, so a previous winner loses
    // ties to everyone else.
    // -------------------------------------------------------------------------
    logic [N_MASTER-1:0] elig;
    logic [MIDX_W-1:0]   cand;
    logic                arb_found;
    logic [MIDX_W-1:0]   arb_idx;

    always_comb begin
        elig      = hold_expire ? (bus.m_req & ~grant) : bus.m_req;
        cand      = '0;
        arb_found = 1'b0;
        arb_idx   = '0;
        for (int i = 1; i <= N_MASTER; i++) begin
            cand = MIDX_W'((int'(rr_ptr) + i) % N_MASTER);
            if (!arb_found && elig[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Arbiter FSM and read-return registers
    // -------------------------------------------------------------------------
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= MIDX_W'(N_MASTER - 1);
            rd_vld   <= 1'b0;
            rd_idx   <= '0;
`ifdef BUS_HOLD_LIMIT_EN
            hold_cnt <= '0;
`endif
        end else begin
            // Captured every edge regardless of what the grant does next, so
            // a read in the last owned cycle still completes.
            rd_vld <= active && !own_wr && hit;
            rd_idx <= SIDX_W'(win);

            case (state)
                IDLE: begin
                    if (arb_found) begin
                        state    <= OWNED;
                        grant    <= N_MASTER'(1) << arb_idx;
                        owner    <= arb_idx;
                        rr_ptr   <= arb_idx;
`ifdef BUS_HOLD_LIMIT_EN
                        hold_cnt <= HCNT_W'(1);
`endif
                    end
                end

                OWNED: begin
                    if (own_req && !hold_expire) begin
                        // Owner keeps the bus.
`ifdef BUS_HOLD_LIMIT_EN
                        hold_cnt <= (hold_cnt == HCNT_W'(HOLD_MAX))
                                  ? HCNT_W'(1) : hold_cnt + HCNT_W'(1);
`endif
                    end else if (arb_found) begin
                        // Hand over in the same edge: no idle bubble.
                        grant    <= N_MASTER'(1) << arb_idx;
                        owner    <= arb_idx;
                        rr_ptr   <= arb_idx;
`ifdef BUS_HOLD_LIMIT_EN
                        hold_cnt <= HCNT_W'(1);
`endif
                    end else begin
                        state    <= IDLE;
                        grant    <= '0;
`ifdef BUS_HOLD_LIMIT_EN
                        hold_cnt <= '0;
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule : bus_arb_nxm
